// File: rtl/sevseg_mux_driver.sv
// Time-multiplexed seven-segment driver for the combo-lock display.
// It scans DIGITS common-anode digits, one slot per digit. Each digit shows
// a hex glyph or a lock-state symbol, with an optional decimal point and
// brightness control. Display content is double-buffered in shadow
// registers. New content is taken only at a frame boundary, so a frame
// never mixes old and new digits.
module sevseg_mux_driver #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000,
   parameter int BRIGHT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     glyph_mode,
   input  logic [DIGITS-1:0]     blank,
   input  logic [DIGITS-1:0]     dp,
   input  logic [BRIGHT_W-1:0]   brightness,
   input  logic                  load,
   output logic                  load_ack,
   output logic                  frame_tick,
   output logic [DIGITS-1:0]     seg_en,
   output logic [6:0]            seg,
   output logic                  dp_n
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(DIGITS);
   // Wide enough to hold (2**BRIGHT_W) * TICK_DIV without overflow.
   localparam int MW = BRIGHT_W + 1 + $clog2(TICK_DIV + 1);

   logic [PW-1:0]       pres;
   logic [SW-1:0]       slot;
   logic                pending;
   logic [4*DIGITS-1:0] sh_digits;
   logic [DIGITS-1:0]   sh_glyph_mode;
   logic [DIGITS-1:0]   sh_blank;
   logic [DIGITS-1:0]   sh_dp;
   logic [BRIGHT_W-1:0] sh_bright;

   logic                at_frame_end;
   logic                capture;
   logic [MW-1:0]       on_prod;
   logic [MW-1:0]       on_cap;
   logic                lit;
   logic [3:0]          code;
   logic [DIGITS-1:0]   nxt_seg_en;
   logic [6:0]          nxt_seg;
   logic                nxt_dp_n;

   function automatic logic [6:0] hex_glyph(input logic [3:0] c);
      logic [6:0] g;
      case (c)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Lock-state symbols: L, U, H, dash. Any other code shows a dark digit.
   function automatic logic [6:0] sym_glyph(input logic [3:0] c);
      logic [6:0] g;
      case (c)
         4'h0: g = 7'b1000111;
         4'h1: g = 7'b1000001;
         4'h2: g = 7'b0001001;
         4'h3: g = 7'b0111111;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   assign at_frame_end = (pres == PW'(TICK_DIV - 1)) && (slot == SW'(DIGITS - 1));
   assign capture      = at_frame_end && (pending || load);

   // The prescaler wraps once per slot. The slot counter advances on each wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         pres <= '0;
         slot <= '0;
      end else if (pres == PW'(TICK_DIV - 1)) begin
         pres <= '0;
         slot <= (slot == SW'(DIGITS - 1)) ? '0 : slot + 1'b1;
      end else begin
         pres <= pres + 1'b1;
      end
   end

   // Hold a load request until the frame boundary, then copy it into the shadows.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending       <= 1'b0;
         sh_digits     <= '0;
         sh_glyph_mode <= '0;
         sh_blank      <= '1;
         sh_dp         <= '0;
         sh_bright     <= '1;
         load_ack      <= 1'b0;
         frame_tick    <= 1'b0;
      end else begin
         load_ack   <= capture;
         frame_tick <= at_frame_end;
         if (capture) begin
            pending       <= 1'b0;
            sh_digits     <= digits;
            sh_glyph_mode <= glyph_mode;
            sh_blank      <= blank;
            sh_dp         <= dp;
            sh_bright     <= brightness;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   // Decide the on-time window and the glyph for the current slot.
   // pres = 0 is always dark so the previous digit cannot ghost into this one.
   always_comb begin
      on_prod    = (MW'(sh_bright) + MW'(1)) * MW'(TICK_DIV);
      on_cap     = on_prod >> BRIGHT_W;
      if (on_cap > MW'(TICK_DIV - 1)) on_cap = MW'(TICK_DIV - 1);
      lit        = (pres != '0) && (MW'(pres) <= on_cap) && !sh_blank[slot];
      code       = sh_digits[{slot, 2'b00} +: 4];
      nxt_seg_en = '1;
      nxt_seg    = 7'h7F;
      nxt_dp_n   = 1'b1;
      if (lit) begin
         nxt_seg_en[slot] = 1'b0;
         nxt_seg          = sh_glyph_mode[slot] ? sym_glyph(code) : hex_glyph(code);
         nxt_dp_n         = ~sh_dp[slot];
      end
   end

   // Register the display outputs so the pins stay glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_en <= '1;
         seg    <= 7'h7F;
         dp_n   <= 1'b1;
      end else begin
         seg_en <= nxt_seg_en;
         seg    <= nxt_seg;
         dp_n   <= nxt_dp_n;
      end
   end

endmodule

// File: tb/tb_sevseg_mux_driver.sv
// Testbench for sevseg_mux_driver with DIGITS=4, TICK_DIV=8, BRIGHT_W=2.
// A frame-level model tracks the cycle count and the shadow content, and
// predicts the registered outputs every cycle. Directed checks at fixed
// cycles pin the model to hand-computed values.
module tb_sevseg_mux_driver;
   localparam int D  = 4;
   localparam int TD = 8;
   localparam int BW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [4*D-1:0] digits;
   logic [D-1:0]   glyph_mode, blank, dp;
   logic [BW-1:0]  brightness;
   logic           load;
   logic           load_ack, frame_tick, dp_n;
   logic [D-1:0]   seg_en;
   logic [6:0]     seg;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   sevseg_mux_driver #(.DIGITS(D), .TICK_DIV(TD), .BRIGHT_W(BW)) dut (
      .clk(clk), .rst(rst), .digits(digits), .glyph_mode(glyph_mode),
      .blank(blank), .dp(dp), .brightness(brightness), .load(load),
      .load_ack(load_ack), .frame_tick(frame_tick), .seg_en(seg_en),
      .seg(seg), .dp_n(dp_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Glyph tables for the model.
   logic [6:0] hex_t [16];
   logic [6:0] sym_t [16];
   initial begin
      hex_t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      for (int i = 0; i < 16; i++) sym_t[i] = 7'b1111111;
      sym_t[0] = 7'b1000111;
      sym_t[1] = 7'b1000001;
      sym_t[2] = 7'b0001001;
      sym_t[3] = 7'b0111111;
   end

   // Model state.
   bit             mvalid = 0;
   int             n, p, s, on;
   bit             pend, lit, atf;
   logic [4*D-1:0] m_dig;
   logic [D-1:0]   m_gm, m_bl, m_dp;
   logic [BW-1:0]  m_br;
   logic [D-1:0]   e_en;
   logic [6:0]     e_seg;
   logic           e_dpn, e_ack, e_tick;
   logic [3:0]     code;

   // Compare and model process. Inputs and outputs are stable at the negedge.
   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_seg_en", 32'(seg_en), 32'(e_en));
         chk("m_seg", 32'(seg), 32'(e_seg));
         chk("m_dp_n", 32'(dp_n), 32'(e_dpn));
         chk("m_load_ack", 32'(load_ack), 32'(e_ack));
         chk("m_frame_tick", 32'(frame_tick), 32'(e_tick));
      end
      if (rst) begin
         n = 0; pend = 0;
         m_dig = '0; m_gm = '0; m_bl = '1; m_dp = '0; m_br = '1;
         e_en = '1; e_seg = 7'h7F; e_dpn = 1'b1; e_ack = 1'b0; e_tick = 1'b0;
         mvalid = 1;
      end else begin
         p  = n % TD;
         s  = (n / TD) % D;
         on = ((int'(m_br) + 1) * TD) >> BW;
         if (on > TD - 1) on = TD - 1;
         lit   = (p >= 1) && (p <= on) && !m_bl[s];
         code  = m_dig[4*s +: 4];
         e_en  = '1;
         e_seg = 7'h7F;
         e_dpn = 1'b1;
         if (lit) begin
            e_en[s] = 1'b0;
            e_seg   = m_gm[s] ? sym_t[code] : hex_t[code];
            e_dpn   = ~m_dp[s];
         end
         atf    = (p == TD - 1) && (s == D - 1);
         e_tick = atf;
         e_ack  = atf && (pend || load);
         if (e_ack) begin
            m_dig = digits; m_gm = glyph_mode; m_bl = blank; m_dp = dp; m_br = brightness;
            pend = 0;
         end else if (load) begin
            pend = 1;
         end
         n++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int k);
      while (cyc < k) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; load = 1'b0;
      step(); step();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; digits = '0; glyph_mode = '0; blank = '0;
      dp = '0; brightness = '0;

      // Reset idle.
      do_reset();
      chk("idle_en_c0", 32'(seg_en), 32'hF);
      goto(31); chk("idle_tick_31", 32'(frame_tick), 0);
      goto(32); chk("idle_tick_32", 32'(frame_tick), 1);
      goto(40); chk("idle_en_40", 32'(seg_en), 32'hF);
      chk("idle_seg_40", 32'(seg), 32'h7F);
      goto(64); chk("idle_tick_64", 32'(frame_tick), 1);

      // Load and hex display.
      do_reset();
      goto(3);
      load = 1'b1; digits = 16'h3210; blank = '0; dp = 4'b0001; brightness = 2'd3;
      glyph_mode = '0;
      goto(4); load = 1'b0;
      goto(31); chk("hex_ack_31", 32'(load_ack), 0);
      goto(32); chk("hex_ack_32", 32'(load_ack), 1);
      goto(34); chk("hex_en_34", 32'(seg_en), 32'hE);
      chk("hex_seg_34", 32'(seg), 32'b1000000);
      chk("hex_dp_34", 32'(dp_n), 0);
      goto(40); chk("hex_en_40", 32'(seg_en), 32'hE);
      goto(41); chk("hex_guard_41", 32'(seg_en), 32'hF);
      chk("hex_guard_seg_41", 32'(seg), 32'h7F);
      goto(42); chk("hex_en_42", 32'(seg_en), 32'hD);
      chk("hex_seg_42", 32'(seg), 32'b1111001);
      chk("hex_dp_42", 32'(dp_n), 1);

      // Dimmest brightness.
      goto(50); brightness = 2'd0; load = 1'b1;
      goto(51); load = 1'b0;
      goto(64); chk("dim_ack_64", 32'(load_ack), 1);
      goto(65); chk("dim_en_65", 32'(seg_en), 32'hF);
      goto(66); chk("dim_en_66", 32'(seg_en), 32'hE);
      goto(67); chk("dim_en_67", 32'(seg_en), 32'hE);
      goto(68); chk("dim_en_68", 32'(seg_en), 32'hF);
      goto(74); chk("dim_en_74", 32'(seg_en), 32'hD);
      goto(76); chk("dim_en_76", 32'(seg_en), 32'hF);

      // Symbols and blanking.
      goto(80);
      glyph_mode = 4'b1111; digits = 16'h7210; blank = 4'b0100; dp = '0;
      brightness = 2'd3; load = 1'b1;
      goto(81); load = 1'b0;
      goto(96); chk("sym_ack_96", 32'(load_ack), 1);
      goto(98); chk("sym_L", 32'(seg), 32'b1000111);
      goto(106); chk("sym_U", 32'(seg), 32'b1000001);
      chk("sym_en1", 32'(seg_en), 32'hD);
      goto(114); chk("sym_blank_en", 32'(seg_en), 32'hF);
      goto(122); chk("sym_dark_en", 32'(seg_en), 32'h7);
      chk("sym_dark_seg", 32'(seg), 32'h7F);

      // Double load.
      do_reset();
      glyph_mode = '0; blank = '0; dp = '0; brightness = 2'd3;
      goto(32); chk("dbl_noack_32", 32'(load_ack), 0);
      goto(40); load = 1'b1; digits = 16'h1111;
      goto(41); load = 1'b0;
      goto(45); load = 1'b1; digits = 16'h2222;
      goto(46); load = 1'b0;
      goto(63); load = 1'b1; digits = 16'h4321;
      goto(64); load = 1'b0;
      chk("dbl_ack_64", 32'(load_ack), 1);
      goto(65); chk("dbl_ack_65", 32'(load_ack), 0);
      goto(66); chk("dbl_seg_66", 32'(seg), 32'b1111001);
      chk("dbl_en_66", 32'(seg_en), 32'hE);

      // Reset while pending.
      do_reset();
      goto(35); load = 1'b1; digits = 16'h5555;
      goto(36); load = 1'b0;
      goto(50); rst = 1'b1;
      goto(51);
      chk("rp_en_51", 32'(seg_en), 32'hF);
      chk("rp_seg_51", 32'(seg), 32'h7F);
      chk("rp_ack_51", 32'(load_ack), 0);
      rst = 1'b0; cyc = 0;
      goto(32); chk("rp_noack_32", 32'(load_ack), 0);
      chk("rp_tick_32", 32'(frame_tick), 1);
      goto(40); chk("rp_dark_40", 32'(seg_en), 32'hF);
      goto(70);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
